// File: rtl/jzjpcc_decode_pipeline.sv
// Decode-to-execute pipeline register with register hazard detection and operand forwarding.
// Optional feature macro: JZJPCC_DECODE_BYPASS_EN (forwarding on; without it every in-flight writer stalls).
module jzjpcc_decode_pipeline #(
    parameter int PC_MAX_B    = 31,
    parameter int CTRL_W      = 8,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:2]            instruction_decode,
    input  logic [PC_MAX_B:2]      currentPC_decode,
    input  logic                   valid_decode,
    input  logic [CTRL_W-1:0]      ctrl_decode,
    input  logic [31:0]            immediate_decode,
    input  logic                   usesRs1_decode,
    input  logic                   usesRs2_decode,
    input  logic                   rdWE_decode,
    input  logic                   isLoad_decode,
    output logic [4:0]             rs1Addr_decode,
    output logic [4:0]             rs2Addr_decode,
    input  logic [31:0]            rs1_decode,
    input  logic [31:0]            rs2_decode,
    input  logic [4:0]             rdAddr_memory,
    input  logic                   rdWE_memory,
    input  logic                   isLoad_memory,
    input  logic [31:0]            rdData_memory,
    input  logic [4:0]             rdAddr_writeback,
    input  logic                   rdWE_writeback,
    input  logic [31:0]            rdData_writeback,
    input  logic                   stall_execute,
    input  logic                   flush_execute,
    output logic                   stall_fetch,
    output logic                   valid_execute,
    output logic [CTRL_W-1:0]      ctrl_execute,
    output logic [31:0]            immediate_execute,
    output logic [PC_MAX_B:2]      currentPC_execute,
    output logic [31:0]            rs1_execute,
    output logic [31:0]            rs2_execute,
    output logic [4:0]             rdAddr_execute,
    output logic                   rdWE_execute,
    output logic                   isLoad_execute,
    output logic [STALL_CNT_W-1:0] hazardStalls
);

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

    function automatic logic src_match(input logic uses, input logic [4:0] rs,
                                       input logic we, input logic [4:0] rd);
        return uses && (rs != 5'd0) && we && (rd == rs);
    endfunction

    logic        ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
    logic        hazard;
    logic        bubble;
    logic [31:0] rs1_fwd, rs2_fwd;
    logic        unused_instr;

    assign rs1Addr_decode = instruction_decode[19:15];
    assign rs2Addr_decode = instruction_decode[24:20];
    assign unused_instr   = ^{instruction_decode[31:25], instruction_decode[14:2]};

    assign ex_m1  = src_match(usesRs1_decode, rs1Addr_decode, valid_execute && rdWE_execute, rdAddr_execute);
    assign ex_m2  = src_match(usesRs2_decode, rs2Addr_decode, valid_execute && rdWE_execute, rdAddr_execute);
    assign mem_m1 = src_match(usesRs1_decode, rs1Addr_decode, rdWE_memory, rdAddr_memory);
    assign mem_m2 = src_match(usesRs2_decode, rs2Addr_decode, rdWE_memory, rdAddr_memory);
    assign wb_m1  = src_match(usesRs1_decode, rs1Addr_decode, rdWE_writeback, rdAddr_writeback);
    assign wb_m2  = src_match(usesRs2_decode, rs2Addr_decode, rdWE_writeback, rdAddr_writeback);

`ifdef JZJPCC_DECODE_BYPASS_EN
    // Only load results are unavailable in time; memory-stage ALU results beat writeback.
    assign hazard  = valid_decode && (((ex_m1 || ex_m2) && isLoad_execute) ||
                                      ((mem_m1 || mem_m2) && isLoad_memory));
    assign rs1_fwd = (mem_m1 && !isLoad_memory) ? rdData_memory :
                     wb_m1 ? rdData_writeback : rs1_decode;
    assign rs2_fwd = (mem_m2 && !isLoad_memory) ? rdData_memory :
                     wb_m2 ? rdData_writeback : rs2_decode;
`else
    logic unused_bypass;
    assign unused_bypass = ^{rdData_memory, rdData_writeback, isLoad_memory};
    assign hazard  = valid_decode && (ex_m1 || ex_m2 || mem_m1 || mem_m2 || wb_m1 || wb_m2);
    assign rs1_fwd = rs1_decode;
    assign rs2_fwd = rs2_decode;
`endif

    assign bubble      = !flush_execute && !stall_execute && hazard;
    assign stall_fetch = stall_execute || (hazard && !flush_execute);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_execute     <= 1'b0;
            ctrl_execute      <= '0;
            immediate_execute <= '0;
            currentPC_execute <= '0;
            rs1_execute       <= '0;
            rs2_execute       <= '0;
            rdAddr_execute    <= '0;
            rdWE_execute      <= 1'b0;
            isLoad_execute    <= 1'b0;
        end else if (flush_execute || bubble) begin
            // Data fields intentionally hold; only the slot's identity is killed.
            valid_execute  <= 1'b0;
            rdWE_execute   <= 1'b0;
            rdAddr_execute <= '0;
            isLoad_execute <= 1'b0;
        end else if (!stall_execute) begin
            valid_execute     <= valid_decode;
            ctrl_execute      <= ctrl_decode;
            immediate_execute <= immediate_decode;
            currentPC_execute <= currentPC_decode;
            rs1_execute       <= rs1_fwd;
            rs2_execute       <= rs2_fwd;
            rdAddr_execute    <= rs_dest(instruction_decode);
            rdWE_execute      <= rdWE_decode && valid_decode;
            isLoad_execute    <= isLoad_decode;
        end
    end

    function automatic logic [4:0] rs_dest(input logic [31:2] instr);
        return instr[11:7];
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hazardStalls <= '0;
        end else if (bubble && (hazardStalls != CNT_MAX)) begin
            hazardStalls <= hazardStalls + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_jzjpcc_decode_pipeline.sv
// Self-checking bench for jzjpcc_decode_pipeline: spec-level model compared every cycle plus pinned literal cases.
// Expectations follow JZJPCC_DECODE_BYPASS_EN in the same way as the design build.
module tb_jzjpcc_decode_pipeline;

`ifdef JZJPCC_DECODE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int CW = 2;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:2] instruction_decode;
    logic [31:2] currentPC_decode;
    logic        valid_decode;
    logic [7:0]  ctrl_decode;
    logic [31:0] immediate_decode;
    logic        usesRs1_decode, usesRs2_decode, rdWE_decode, isLoad_decode;
    logic [4:0]  rs1Addr_decode, rs2Addr_decode;
    logic [31:0] rs1_decode, rs2_decode;
    logic [4:0]  rdAddr_memory;
    logic        rdWE_memory, isLoad_memory;
    logic [31:0] rdData_memory;
    logic [4:0]  rdAddr_writeback;
    logic        rdWE_writeback;
    logic [31:0] rdData_writeback;
    logic        stall_execute, flush_execute;
    logic        stall_fetch;
    logic        valid_execute;
    logic [7:0]  ctrl_execute;
    logic [31:0] immediate_execute;
    logic [31:2] currentPC_execute;
    logic [31:0] rs1_execute, rs2_execute;
    logic [4:0]  rdAddr_execute;
    logic        rdWE_execute, isLoad_execute;
    logic [CW-1:0] hazardStalls;

    int checks = 0;
    int errors = 0;

    jzjpcc_decode_pipeline #(.PC_MAX_B(31), .CTRL_W(8), .STALL_CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .instruction_decode(instruction_decode), .currentPC_decode(currentPC_decode),
        .valid_decode(valid_decode), .ctrl_decode(ctrl_decode), .immediate_decode(immediate_decode),
        .usesRs1_decode(usesRs1_decode), .usesRs2_decode(usesRs2_decode),
        .rdWE_decode(rdWE_decode), .isLoad_decode(isLoad_decode),
        .rs1Addr_decode(rs1Addr_decode), .rs2Addr_decode(rs2Addr_decode),
        .rs1_decode(rs1_decode), .rs2_decode(rs2_decode),
        .rdAddr_memory(rdAddr_memory), .rdWE_memory(rdWE_memory),
        .isLoad_memory(isLoad_memory), .rdData_memory(rdData_memory),
        .rdAddr_writeback(rdAddr_writeback), .rdWE_writeback(rdWE_writeback),
        .rdData_writeback(rdData_writeback),
        .stall_execute(stall_execute), .flush_execute(flush_execute),
        .stall_fetch(stall_fetch),
        .valid_execute(valid_execute), .ctrl_execute(ctrl_execute),
        .immediate_execute(immediate_execute), .currentPC_execute(currentPC_execute),
        .rs1_execute(rs1_execute), .rs2_execute(rs2_execute),
        .rdAddr_execute(rdAddr_execute), .rdWE_execute(rdWE_execute),
        .isLoad_execute(isLoad_execute), .hazardStalls(hazardStalls)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          m_valid, m_rdWE, m_isLoad;
    logic [4:0]    m_rdAddr;
    logic [7:0]    m_ctrl;
    logic [31:0]   m_imm, m_rs1, m_rs2;
    logic [31:2]   m_pc;
    logic [CW-1:0] m_cnt;

    // Does the decode instruction read register rd, written by a writer with enable we?
    function automatic logic reads(input logic [4:0] rd, input logic we);
        logic [4:0] a1, a2;
        a1 = instruction_decode[19:15];
        a2 = instruction_decode[24:20];
        return we && (rd != 5'd0) &&
               ((usesRs1_decode && a1 == rd) || (usesRs2_decode && a2 == rd));
    endfunction

    function automatic logic m_hazard();
        if (!valid_decode) return 1'b0;
        if (BYP)
            return (reads(m_rdAddr, m_valid && m_rdWE) && m_isLoad) ||
                   (reads(rdAddr_memory, rdWE_memory) && isLoad_memory);
        return reads(m_rdAddr, m_valid && m_rdWE) || reads(rdAddr_memory, rdWE_memory) ||
               reads(rdAddr_writeback, rdWE_writeback);
    endfunction

    function automatic logic [31:0] m_operand(input logic uses, input logic [4:0] a,
                                              input logic [31:0] regval);
        if (!BYP || !uses || a == 5'd0) return regval;
        if (rdWE_memory && !isLoad_memory && rdAddr_memory == a) return rdData_memory;
        if (rdWE_writeback && rdAddr_writeback == a) return rdData_writeback;
        return regval;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_valid <= 0; m_rdWE <= 0; m_isLoad <= 0; m_rdAddr <= 0;
            m_ctrl <= 0; m_imm <= 0; m_rs1 <= 0; m_rs2 <= 0; m_pc <= 0; m_cnt <= 0;
        end else if (flush_execute) begin
            m_valid <= 0; m_rdWE <= 0; m_rdAddr <= 0; m_isLoad <= 0;
        end else if (stall_execute) begin
            m_valid <= m_valid;
        end else if (m_hazard()) begin
            m_valid <= 0; m_rdWE <= 0; m_rdAddr <= 0; m_isLoad <= 0;
            if (m_cnt != CMAX) m_cnt <= m_cnt + 1'b1;
        end else begin
            m_valid  <= valid_decode;
            m_rdWE   <= rdWE_decode && valid_decode;
            m_rdAddr <= instruction_decode[11:7];
            m_isLoad <= isLoad_decode;
            m_ctrl   <= ctrl_decode;
            m_imm    <= immediate_decode;
            m_pc     <= currentPC_decode;
            m_rs1    <= m_operand(usesRs1_decode, instruction_decode[19:15], rs1_decode);
            m_rs2    <= m_operand(usesRs2_decode, instruction_decode[24:20], rs2_decode);
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            check("valid_execute", valid_execute, m_valid);
            check("rdWE_execute", rdWE_execute, m_rdWE);
            check("rdAddr_execute", rdAddr_execute, m_rdAddr);
            check("isLoad_execute", isLoad_execute, m_isLoad);
            check("ctrl_execute", ctrl_execute, m_ctrl);
            check("immediate_execute", immediate_execute, m_imm);
            check("currentPC_execute", currentPC_execute, m_pc);
            check("rs1_execute", rs1_execute, m_rs1);
            check("rs2_execute", rs2_execute, m_rs2);
            check("hazardStalls", hazardStalls, m_cnt);
            check("stall_fetch", stall_fetch, stall_execute || (m_hazard() && !flush_execute));
            check("rs1Addr_decode", rs1Addr_decode, instruction_decode[19:15]);
            check("rs2Addr_decode", rs2Addr_decode, instruction_decode[24:20]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        instruction_decode = '0; currentPC_decode = '0; valid_decode = 0; ctrl_decode = '0;
        immediate_decode = '0; usesRs1_decode = 0; usesRs2_decode = 0; rdWE_decode = 0;
        isLoad_decode = 0; rs1_decode = '0; rs2_decode = '0;
        rdAddr_memory = '0; rdWE_memory = 0; isLoad_memory = 0; rdData_memory = '0;
        rdAddr_writeback = '0; rdWE_writeback = 0; rdData_writeback = '0;
        stall_execute = 0; flush_execute = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        @(negedge clock);
        reset = 1'b1;
        step();
    endtask

    task automatic dec(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [4:0] rd, input logic we,
                       input logic ld, input logic [31:0] imm);
        instruction_decode        = '0;
        instruction_decode[31:25] = 7'h33;
        instruction_decode[24:20] = a2;
        instruction_decode[19:15] = a1;
        instruction_decode[11:7]  = rd;
        valid_decode     = 1; usesRs1_decode = 1; usesRs2_decode = 1;
        rs1_decode       = v1; rs2_decode = v2;
        rdWE_decode      = we; isLoad_decode = ld;
        immediate_decode = imm;
        ctrl_decode      = imm[7:0] ^ 8'h5A;
        currentPC_decode = imm[31:2] ^ 30'h155;
    endtask

    initial begin
        idle();
        #3;
        check("reset_valid", valid_execute, 0);
        check("reset_imm", immediate_execute, 0);
        check("reset_cnt", hazardStalls, 0);
        do_reset();

        // Plain issue, no writers in flight
        dec(5'd1, 5'd2, 32'h100, 32'h200, 5'd3, 1, 0, 32'h0000_0A00);
        step();
        check("plain_valid", valid_execute, 1);
        check("plain_rs1", rs1_execute, 32'h100);
        check("plain_rd", rdAddr_execute, 3);

        // ALU result x5 in memory
        do_reset();
        dec(5'd5, 5'd0, 32'h0, 32'h0, 5'd12, 1, 0, 32'h18);
        rdAddr_memory = 5'd5; rdWE_memory = 1; rdData_memory = 32'h11;
        #1 check("alu_mem_stall", stall_fetch, BYP ? 0 : 1);
        step();
        check("alu_mem_valid", valid_execute, BYP ? 1 : 0);
        check("alu_mem_rs1", rs1_execute, BYP ? 32'h11 : 32'h0);

        // x6 in memory and writeback, memory wins
        do_reset();
        dec(5'd0, 5'd6, 32'h0, 32'h0, 5'd12, 1, 0, 32'h19);
        rdAddr_memory = 5'd6; rdWE_memory = 1; rdData_memory = 32'hAA;
        rdAddr_writeback = 5'd6; rdWE_writeback = 1; rdData_writeback = 32'hBB;
        step();
        check("mem_over_wb_rs2", rs2_execute, BYP ? 32'hAA : 32'h0);

        // Load-use on x7
        do_reset();
        dec(5'd1, 5'd2, 32'h1, 32'h2, 5'd7, 1, 1, 32'h20);
        step();
        dec(5'd7, 5'd0, 32'h0, 32'h0, 5'd8, 1, 0, 32'h21);
        #1 check("ld_stall1", stall_fetch, 1);
        step();
        check("ld_bubble1", valid_execute, 0);
        check("ld_cnt1", hazardStalls, 1);
        rdAddr_memory = 5'd7; rdWE_memory = 1; isLoad_memory = 1;
        step();
        check("ld_bubble2", valid_execute, 0);
        check("ld_cnt2", hazardStalls, 2);
        rdAddr_memory = 5'd0; rdWE_memory = 0; isLoad_memory = 0;
        rdAddr_writeback = 5'd7; rdWE_writeback = 1; rdData_writeback = 32'h77;
        step();
        check("ld_issue_wb", valid_execute, BYP ? 1 : 0);
        rdAddr_writeback = 5'd0; rdWE_writeback = 0; rs1_decode = 32'h77;
        step();
        check("ld_issue_valid", valid_execute, 1);
        check("ld_issue_rs1", rs1_execute, 32'h77);
        check("ld_issue_cnt", hazardStalls, BYP ? 2 : 3);

        // Downstream hold, then flush during hold
        do_reset();
        dec(5'd1, 5'd2, 32'h1111, 32'h2222, 5'd4, 1, 0, 32'hCAFE_0000);
        step();
        stall_execute = 1;
        dec(5'd3, 5'd0, 32'h3333, 32'h0, 5'd13, 1, 0, 32'hDEAD_0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_imm", immediate_execute, 32'hCAFE_0000);
            check("hold_rs1", rs1_execute, 32'h1111);
            check("hold_valid", valid_execute, 1);
        end
        flush_execute = 1;
        step();
        check("flush_over_stall_valid", valid_execute, 0);
        check("flush_over_stall_rd", rdAddr_execute, 0);
        check("flush_keeps_imm", immediate_execute, 32'hCAFE_0000);

        // Saturating counter, then async reset while held
        do_reset();
        rdAddr_memory = 5'd9; rdWE_memory = 1; isLoad_memory = 1;
        dec(5'd9, 5'd0, 32'h0, 32'h0, 5'd10, 1, 0, 32'h30);
        for (int i = 1; i <= 5; i++) begin
            step();
            check("sat_cnt", hazardStalls, (i > 3) ? 3 : i);
        end
        stall_execute = 1;
        step();
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", valid_execute, 0);
        check("async_rst_cnt", hazardStalls, 0);
        check("async_rst_imm", immediate_execute, 0);
        idle();
        dec(5'd1, 5'd2, 32'h55, 32'h66, 5'd11, 1, 0, 32'h1234);
        @(negedge clock);
        reset = 1'b1;
        step();
        check("post_rst_valid", valid_execute, 1);
        check("post_rst_rs1", rs1_execute, 32'h55);
        check("post_rst_imm", immediate_execute, 32'h1234);

        // x0 never forwarded, never stalls
        do_reset();
        rdAddr_memory = 5'd0; rdWE_memory = 1; rdData_memory = 32'hFFFF;
        rdAddr_writeback = 5'd0; rdWE_writeback = 1; rdData_writeback = 32'hEEEE;
        dec(5'd0, 5'd0, 32'h0, 32'h0, 5'd14, 1, 0, 32'h40);
        #1 check("x0_stall", stall_fetch, 0);
        step();
        check("x0_rs1", rs1_execute, 0);
        check("x0_valid", valid_execute, 1);

        // Flush suppresses the hazard stall and the count
        do_reset();
        rdAddr_memory = 5'd9; rdWE_memory = 1; isLoad_memory = 1;
        dec(5'd9, 5'd0, 32'h0, 32'h0, 5'd10, 1, 0, 32'h50);
        flush_execute = 1;
        #1 check("flush_haz_stall", stall_fetch, 0);
        step();
        check("flush_haz_cnt", hazardStalls, 0);
        check("flush_haz_valid", valid_execute, 0);

        idle();
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jzjpcc_decode_pipeline.md
JZJPCC_DECODE_PIPELINE -- requirements
Module: jzjpcc_decode_pipeline

Interface
REQ-001 SHALL have parameter PC_MAX_B, default 31, MSB of word-aligned PC.
REQ-002 SHALL have parameter CTRL_W, default 8, width of opaque control bundle from jzjpcc_control.
REQ-003 SHALL have parameter STALL_CNT_W, default 16, width of hazard stall counter.
REQ-004 Ports (name  direction  width  meaning):
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset
instruction_decode  in  30  instruction bits [31:2]
currentPC_decode  in  PC_MAX_B-1  PC bits [PC_MAX_B:2]
valid_decode  in  1  decode slot holds a real instruction
ctrl_decode  in  CTRL_W  decoded control bundle
immediate_decode  in  32  formed immediate
usesRs1_decode / usesRs2_decode  in  1 each  instruction reads rs1 / rs2
rdWE_decode / isLoad_decode  in  1 each  writes rd / is a load
rs1Addr_decode / rs2Addr_decode  out  5 each  = instruction_decode[19:15] / [24:20]
rs1_decode / rs2_decode  in  32 each  register file read data
rdAddr_memory / rdWE_memory / isLoad_memory / rdData_memory  in  5/1/1/32  memory-stage writer
rdAddr_writeback / rdWE_writeback / rdData_writeback  in  5/1/32  writeback-stage writer
stall_execute  in  1  downstream hold
flush_execute  in  1  squash instruction entering execute
stall_fetch  out  1  hold fetch and decode this cycle
valid_execute / ctrl_execute / immediate_execute / currentPC_execute  out  1/CTRL_W/32/PC_MAX_B-1  execute register
rs1_execute / rs2_execute  out  32 each  forwarded operands
rdAddr_execute / rdWE_execute / isLoad_execute  out  5/1/1  execute destination info
hazardStalls  out  STALL_CNT_W  saturating count of hazard bubbles

Function
REQ-005 A source matches rsN when usesRsN_decode, rsN address != 0, source WE = 1, source rdAddr = rsN address.
REQ-006 Forwarding (macro defined): rsN_execute <= memory match and !isLoad_memory ? rdData_memory : writeback match ? rdData_writeback : rsN_decode; memory beats writeback.
REQ-007 hazard (macro defined) = valid_decode and (execute match with valid_execute and isLoad_execute, or memory match with isLoad_memory).
REQ-008 stall_fetch = stall_execute or (hazard and !flush_execute); combinational, no latency.
REQ-009 Execute-register update priority per rising edge: flush_execute -> valid_execute<=0, rdWE_execute<=0, rdAddr_execute<=0, isLoad_execute<=0; else stall_execute -> all outputs hold; else hazard -> same bubble as flush; else load all fields from decode inputs, valid_execute<=valid_decode, rdWE_execute<=rdWE_decode and valid_decode.
REQ-010 flush_execute overrides stall_execute in the same cycle.
REQ-011 Data fields (immediate, PC, operands, ctrl) SHALL hold unchanged on bubble/flush; only valid/rd fields cleared.
REQ-012 hazardStalls increments by 1 each cycle a hazard bubble is inserted (REQ-009 third branch), saturates at all-ones, never wraps.
REQ-013 x0 never forwarded nor causes a hazard.

Reset
REQ-014 reset low asynchronously clears every execute-register output and hazardStalls to 0; release synchronous to clock next edge.
REQ-015 Reset mid-stall discards the held instruction; first post-reset edge loads decode inputs normally.

Configuration
REQ-016 Macro JZJPCC_DECODE_BYPASS_EN: defined -> REQ-006/REQ-007 apply.
REQ-017 Undefined -> no forwarding (rsN_execute <= rsN_decode); hazard = valid_decode and any match in execute (valid_execute), memory, or writeback; counter and REQ-009 unchanged.

Verification
REQ-018 ALU write x5=0x11 in memory, decode reads x5 -> rs1_execute=0x11, stall_fetch=0.
REQ-019 x6 written by memory (0xAA) and writeback (0xBB), decode reads x6 -> rs2_execute=0xAA.
REQ-020 load to x7 in execute, decode uses x7 -> two bubbles (valid_execute=0), hazardStalls=2, then instruction issues with loaded data via writeback.
REQ-021 stall_execute=1 and flush_execute=1 same edge -> valid_execute=0; stall_execute alone 3 cycles -> outputs unchanged.
REQ-022 STALL_CNT_W=2, five hazard bubbles -> hazardStalls=3; reset low mid-stall -> all outputs 0 immediately.
REQ-023 macro undefined, ALU write x5 in writeback, decode reads x5 -> stall_fetch=1, one bubble.
